apb_requester: RTL and testbench

- APB initiator: the bus-master end of the APB completer/RAM slave already in the design.
- Accepts single read/write commands on a valid/ready command port and runs standard APB SETUP→ACCESS transfers.
- Waits on pREADY and returns read data (or a timeout error) on a one-cycle response port.
- Sits between the system-side controller/test sequencer and the APB completer.

---
 rtl/apb_requester.sv | 161 ++++++++++++++++
 tb/tb_apb_requester.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB initiator: accepts single read/write commands and runs SETUP/ACCESS transfers,
// returning read data or a timeout error on a one-cycle response pulse.
module apb_requester #(
  parameter int unsigned ADDr_WIDTH  = 8,
  parameter int unsigned Data_WIDTH  = 32,
  parameter int unsigned pSTRB_WIDTH = Data_WIDTH / 8,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDr_WIDTH-1:0]  cmd_addr,
  input  logic [Data_WIDTH-1:0]  cmd_wdata,
  input  logic [pSTRB_WIDTH-1:0] cmd_strb,
  output logic                   rsp_valid,
  output logic [Data_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic                   psel,
  output logic                   penable,
  output logic                   pWRITE,
  output logic [ADDr_WIDTH-1:0]  pADDr,
  output logic [Data_WIDTH-1:0]  pWDATA,
  output logic [pSTRB_WIDTH-1:0] pSTRB,
  input  logic                   pREADY,
  input  logic [Data_WIDTH-1:0]  pRDATA
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDr_WIDTH-1:0]  paddr_q, paddr_d;
  logic [Data_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [pSTRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [Data_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   accept;
  logic                   timed_out;
  logic [Data_WIDTH-1:0]  load_wdata;
  logic [pSTRB_WIDTH-1:0] load_strb;

  assign cmd_ready = (state_q == StIdle) || ((state_q == StAccess) && pREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Reads keep the previous write data on the bus and drive no strobes.
  assign load_wdata = cmd_write ? cmd_wdata : pwdata_q;
  assign load_strb  = cmd_write ? cmd_strb : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StSetup;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = load_wdata;
          pstrb_d   = load_strb;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (pREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : pRDATA;
          if (accept) begin
            state_d   = StSetup;
            cnt_d     = '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = load_wdata;
            pstrb_d   = load_strb;
          end else begin
            state_d   = StIdle;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (timed_out) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pWRITE    = pwrite_q;
  assign pADDr     = paddr_q;
  assign pWDATA    = pwdata_q;
  assign pSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: RAM completer with configurable wait states, response scoreboard,
// and directed checks of latency, back-to-back, strobes, timeout and async reset.
module tb_apb_requester;

  logic        pclk;
  logic        prst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pWRITE;
  logic [7:0]  pADDr;
  logic [31:0] pWDATA;
  logic [3:0]  pSTRB;
  logic        pREADY;
  logic [31:0] pRDATA;

  apb_requester #(
    .ADDr_WIDTH (8),
    .Data_WIDTH (32),
    .pSTRB_WIDTH(4),
    .TIMEOUT    (16)
  ) dut (
    .pclk     (pclk),
    .prst     (prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_strb (cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pWRITE   (pWRITE),
    .pADDr    (pADDr),
    .pWDATA   (pWDATA),
    .pSTRB    (pSTRB),
    .pREADY   (pREADY),
    .pRDATA   (pRDATA)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  localparam logic [31:0] InitWord = 32'hAABBCCDD;

  // Completer: RAM with ws wait states per access; stall holds pREADY low forever.
  logic [31:0] mem [256];
  int unsigned ws;
  bit          stall;
  int unsigned wcnt;

  assign pREADY = psel && penable && !stall && (wcnt >= ws);
  assign pRDATA = mem[pADDr];

  always @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < 256; i++) mem[i] <= InitWord;
      wcnt <= 0;
    end else begin
      if (psel && penable && !pREADY) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (psel && penable && pREADY && pWRITE) begin
        for (int b = 0; b < 4; b++) if (pSTRB[b]) mem[pADDr][8*b +: 8] <= pWDATA[8*b +: 8];
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [256];
  int          n_cmp;
  int          n_err;
  int          rsp_count;
  int          psel_falls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = InitWord;
  endtask

  always @(negedge pclk) begin
    if (!prst && rsp_valid) begin
      exp_t e;
      rsp_count++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check_eq("sb_rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  always @(negedge psel) psel_falls++;

  // Drives one command and returns #1 after its accept edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_err, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_accept_wait", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      e.err = exp_err;
      if (exp_err) begin
        e.rdata = '0;
      end else if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        e.rdata = '0;
      end else begin
        e.rdata = ref_mem[a];
      end
      sb_q.push_back(e);
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts post-edge samples with penable high until the transfer ends.
  task automatic count_access(output int c);
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge pclk);
      #1;
      if (!penable) break;
      c++;
    end
  endtask

  int cyc;
  int snap_rsp;
  int snap_falls;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rsp_count  = 0;
    psel_falls = 0;
    ws         = 0;
    stall      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    prst       = 1'b1;
    ref_reset();
    repeat (3) @(negedge pclk);
    check_eq("rst_psel", {31'b0, psel}, 32'd0);
    check_eq("rst_penable", {31'b0, penable}, 32'd0);
    check_eq("rst_pwrite", {31'b0, pWRITE}, 32'd0);
    check_eq("rst_paddr", {24'b0, pADDr}, 32'd0);
    check_eq("rst_pwdata", pWDATA, 32'd0);
    check_eq("rst_pstrb", {28'b0, pSTRB}, 32'd0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, 30'b0} | rsp_rdata, 32'd0);
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    prst = 1'b0;

    // Asynchronous reset while stuck in ACCESS
    stall = 1'b1;
    issue(1'b0, 8'h50, 32'h0, 4'h0, 1'b0, 1'b0);
    @(posedge pclk);
    #1;
    check_eq("mid_access_penable", {31'b0, penable}, 32'd1);
    #2;
    prst = 1'b1;
    #1;
    check_eq("async_rst_psel", {31'b0, psel}, 32'd0);
    check_eq("async_rst_penable", {31'b0, penable}, 32'd0);
    @(posedge pclk);
    @(negedge pclk);
    stall = 1'b0;
    ref_reset();
    prst = 1'b0;
    snap_rsp = rsp_count;
    repeat (6) @(negedge pclk);
    check_eq("no_rsp_after_rst", 32'(rsp_count - snap_rsp), 32'd0);

    // Zero-wait write
    ws = 0;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    check_eq("wr_psel_n1", {31'b0, psel}, 32'd1);
    check_eq("wr_penable_n1", {31'b0, penable}, 32'd0);
    check_eq("wr_pstrb_setup", {28'b0, pSTRB}, 32'hF);
    @(posedge pclk);
    #1;
    check_eq("wr_penable_n2", {31'b0, penable}, 32'd1);
    check_eq("wr_pstrb_access", {28'b0, pSTRB}, 32'hF);
    check_eq("wr_paddr", {24'b0, pADDr}, 32'h10);
    check_eq("wr_pwdata", pWDATA, 32'hDEADBEEF);
    check_eq("wr_pwrite", {31'b0, pWRITE}, 32'd1);
    @(posedge pclk);
    #1;
    check_eq("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    check_eq("wr_psel_done", {31'b0, psel}, 32'd0);

    // Read with one wait state
    ws = 1;
    issue(1'b0, 8'h10, 32'h0, 4'hF, 1'b0, 1'b1);
    check_eq("rd_pstrb", {28'b0, pSTRB}, 32'd0);
    check_eq("rd_pwrite", {31'b0, pWRITE}, 32'd0);
    count_access(cyc);
    check_eq("rd_penable_cycles", 32'(cyc), 32'd2);
    check_eq("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("rd_rdata", rsp_rdata, 32'hDEADBEEF);

    // Back-to-back writes
    ws = 0;
    snap_rsp   = rsp_count;
    snap_falls = psel_falls;
    issue(1'b1, 8'h20, 32'h01020304, 4'hF, 1'b0, 1'b1);
    issue(1'b1, 8'h21, 32'h05060708, 4'hF, 1'b0, 1'b1);
    check_eq("b2b_psel_held", {31'b0, psel}, 32'd1);
    check_eq("b2b_penable_gap", {31'b0, penable}, 32'd0);
    check_eq("b2b_paddr2", {24'b0, pADDr}, 32'h21);
    check_eq("b2b_no_psel_drop", 32'(psel_falls - snap_falls), 32'd0);
    @(posedge pclk);
    #1;
    check_eq("b2b_penable_back", {31'b0, penable}, 32'd1);
    @(posedge pclk);
    #1;
    check_eq("b2b_rsp2", {31'b0, rsp_valid}, 32'd1);
    @(negedge pclk);
    check_eq("b2b_rsp_count", 32'(rsp_count - snap_rsp), 32'd2);

    // Partial strobe write then read back
    issue(1'b1, 8'h30, 32'h11223344, 4'b0101, 1'b0, 1'b1);
    check_eq("ps_pstrb", {28'b0, pSTRB}, 32'h5);
    count_access(cyc);
    issue(1'b0, 8'h30, 32'h0, 4'h0, 1'b0, 1'b1);
    count_access(cyc);
    check_eq("ps_rdata", rsp_rdata, 32'hAA22CC44);

    // Timeout: completer never ready
    stall = 1'b1;
    issue(1'b0, 8'h40, 32'h0, 4'h0, 1'b1, 1'b1);
    count_access(cyc);
    check_eq("to_access_cycles", 32'(cyc), 32'd16);
    check_eq("to_psel", {31'b0, psel}, 32'd0);
    check_eq("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    check_eq("to_rsp_rdata", rsp_rdata, 32'd0);

    // Ready arrives on the 16th ACCESS cycle: completion wins over timeout
    stall = 1'b0;
    ws    = 15;
    issue(1'b0, 8'h40, 32'h0, 4'h0, 1'b0, 1'b1);
    count_access(cyc);
    check_eq("late_access_cycles", 32'(cyc), 32'd16);
    check_eq("late_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("late_rsp_err", {31'b0, rsp_err}, 32'd0);
    check_eq("late_rsp_rdata", rsp_rdata, InitWord);

    repeat (4) @(negedge pclk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
